// File: rtl/param_stream_loader.sv
// param_stream_loader: turns a header word plus BEATS payload words per row into CSRAM row writes.
module param_stream_loader #(
    parameter int NUM_CORES_NEW = 9,
    parameter int CSRAM_WIDTH   = 368,
    parameter int NUM_NEURONS   = 256,
    parameter int IN_WIDTH      = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [IN_WIDTH-1:0]              s_data,
    output logic                             param_wen,
    output logic [$clog2(NUM_CORES_NEW)-1:0] param_core_sel,
    output logic [$clog2(NUM_NEURONS)-1:0]   param_addr,
    output logic [CSRAM_WIDTH-1:0]           param_data_in,
    output logic                             busy,
    output logic                             done,
    output logic                             err
);
    localparam int BEATS = (CSRAM_WIDTH + IN_WIDTH - 1) / IN_WIDTH;
    localparam int BW = $clog2(BEATS + 1);
    localparam int RW = $clog2(NUM_NEURONS + 1);
    localparam int CW = $clog2(NUM_CORES_NEW);
    localparam int AW = $clog2(NUM_NEURONS);

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;
    state_t state, state_nx;

    logic [BW-1:0]             beat;
    logic [RW-1:0]             rows_left;
    logic [BEATS*IN_WIDTH-1:0] row_buf, row_nx;
    logic [31:0]               h_rows, h_core, h_start;
    logic                      xfer, hdr_ok, last_beat, hdr_take;

    assign xfer      = s_valid & s_ready;
    assign h_rows    = 32'(s_data[8:0]);
    assign h_core    = 32'(s_data[23:16]);
    assign h_start   = 32'(s_data[31:24]);
    assign hdr_ok    = h_core < NUM_CORES_NEW && h_rows != 0 && h_rows <= NUM_NEURONS
                       && h_start + h_rows <= NUM_NEURONS;
    assign last_beat = beat == BW'(BEATS - 1);
    assign hdr_take  = state == IDLE && xfer && hdr_ok;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = hdr_take ? COLLECT : IDLE;
            COLLECT: state_nx = xfer && last_beat ? WRITE : COLLECT;
            WRITE:   state_nx = rows_left == RW'(1) ? DONE : COLLECT;
            default: state_nx = IDLE;
        endcase
    end

    // rst gates s_ready so nothing is accepted while reset is held
    always_comb begin
        s_ready   = ~rst & (state == IDLE || state == COLLECT);
        param_wen = state == WRITE;
        busy      = state != IDLE;
        done      = state == DONE;
    end

    always_comb begin
        row_nx = row_buf;
        row_nx[beat*IN_WIDTH +: IN_WIDTH] = s_data;
    end

    // bits of row_nx above CSRAM_WIDTH-1 are simply never copied out
    always_ff @(posedge clk) begin
        if (rst) begin
            beat           <= '0;
            rows_left      <= '0;
            row_buf        <= '0;
            param_core_sel <= '0;
            param_addr     <= '0;
            param_data_in  <= '0;
            err            <= 1'b0;
        end else begin
            err <= state == IDLE && xfer && !hdr_ok;
            if (hdr_take) begin
                param_core_sel <= h_core[CW-1:0];
                param_addr     <= h_start[AW-1:0];
                rows_left      <= h_rows[RW-1:0];
                beat           <= '0;
            end
            if (state == COLLECT && xfer) begin
                row_buf <= row_nx;
                beat    <= last_beat ? '0 : beat + 1'b1;
                if (last_beat) param_data_in <= row_nx[CSRAM_WIDTH-1:0];
            end
            if (state == WRITE) begin
                rows_left <= rows_left - 1'b1;
                if (rows_left != RW'(1)) param_addr <= param_addr + 1'b1;
            end
        end
    end
endmodule
